// File: rtl/systolic_fir_chain.sv
// Transposed-form systolic FIR chain behind a valid/ready command stream.
// Optional output saturation: define SYSTOLIC_FIR_SAT_EN.
module systolic_fir_chain #(
  parameter int NUM_PE = 4,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_cmd,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_sat,
  output logic [$clog2(NUM_PE)-1:0] wptr
);

  localparam int ACC_W = 2 * DATA_W + $clog2(NUM_PE);
  localparam int PTR_W = $clog2(NUM_PE);

  typedef enum logic [1:0] {
    CMD_SAMPLE = 2'b00,
    CMD_WEIGHT = 2'b01,
    CMD_CLEAR  = 2'b10,
    CMD_NOP    = 2'b11
  } cmd_e;

  cmd_e cmd;
  logic accept;

  logic signed [DATA_W-1:0]   w        [NUM_PE];
  logic signed [ACC_W-1:0]    p        [NUM_PE-1];
  logic signed [2*DATA_W-1:0] prod     [NUM_PE];
  logic signed [ACC_W-1:0]    prod_ext [NUM_PE];
  logic        [OUT_W-1:0]    y_next;

  assign cmd      = cmd_e'(in_cmd);
  assign in_ready = ena & ((cmd != CMD_SAMPLE) | ~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      prod[i]     = w[i] * $signed(in_data);
      prod_ext[i] = ACC_W'(prod[i]);
    end
  end

`ifdef SYSTOLIC_FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] y_acc;
  logic                    sat_next;

  assign y_acc = prod_ext[0] + p[0];

  always_comb begin
    sat_next = 1'b0;
    y_next   = y_acc[OUT_W-1:0];
    if (y_acc > SAT_MAX) begin
      sat_next = 1'b1;
      y_next   = SAT_MAX[OUT_W-1:0];
    end else if (y_acc < SAT_MIN) begin
      sat_next = 1'b1;
      y_next   = SAT_MIN[OUT_W-1:0];
    end
  end
`else
  // Plain two's-complement wrap of the full-width sum.
  assign y_next  = OUT_W'(prod_ext[0] + p[0]);
  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PE; i++) w[i] <= '0;
      for (int unsigned i = 0; i < NUM_PE - 1; i++) p[i] <= '0;
      wptr      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef SYSTOLIC_FIR_SAT_EN
      out_sat   <= 1'b0;
`endif
    end else if (ena) begin
      // A same-cycle SAMPLE below overrides this clear, giving full throughput.
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        unique case (cmd)
          CMD_SAMPLE: begin
            for (int unsigned i = 0; i < NUM_PE - 2; i++) p[i] <= p[i+1] + prod_ext[i+1];
            p[NUM_PE-2] <= prod_ext[NUM_PE-1];
            out_data    <= y_next;
            out_valid   <= 1'b1;
`ifdef SYSTOLIC_FIR_SAT_EN
            out_sat     <= sat_next;
`endif
          end
          CMD_WEIGHT: begin
            w[wptr] <= $signed(in_data);
            wptr    <= (wptr == PTR_W'(NUM_PE - 1)) ? '0 : wptr + PTR_W'(1);
          end
          CMD_CLEAR: begin
            for (int unsigned i = 0; i < NUM_PE - 1; i++) p[i] <= '0;
            wptr <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_systolic_fir_chain.sv
// Self-checking bench for systolic_fir_chain: vector table, directed corner cases
// and a scoreboard fed by a transposed-FIR reference model with per-sample weight snapshots.
module tb_systolic_fir_chain;

  localparam int NUM_PE = 4;
  localparam int DATA_W = 8;
  localparam int OUT_W  = 16;

  localparam logic [1:0] C_SAMPLE = 2'b00;
  localparam logic [1:0] C_WEIGHT = 2'b01;
  localparam logic [1:0] C_CLEAR  = 2'b10;
  localparam logic [1:0] C_NOP    = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_cmd;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;
  logic [1:0]        wptr;

  systolic_fir_chain #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .wptr(wptr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct { int d; int s; } res_t;
  res_t q[$];

  int mw [NUM_PE];
  int mptr;
  int hx [NUM_PE];
  int hw [NUM_PE][NUM_PE];

  task automatic model_reset(input bit weights_too);
    for (int k = 0; k < NUM_PE; k++) begin
      hx[k] = 0;
      for (int j = 0; j < NUM_PE; j++) hw[k][j] = 0;
      if (weights_too) mw[k] = 0;
    end
    mptr = 0;
  endtask

  task automatic shape_out(input int y, output int d, output int s);
    logic signed [15:0] t;
`ifdef SYSTOLIC_FIR_SAT_EN
    if (y > 32767)       begin d = 32767;  s = 1; end
    else if (y < -32768) begin d = -32768; s = 1; end
    else                 begin d = y;      s = 0; end
`else
    t = y[15:0];
    d = int'(t);
    s = 0;
`endif
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      model_reset(1'b1);
    end else begin
      if (ena && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got out_data=%0d with no expected result queued", $signed(out_data));
        end else begin
          res_t e;
          e = q.pop_front();
          check("sb_data", int'($signed(out_data)), e.d);
          check("sb_sat", int'(out_sat), e.s);
        end
      end
      if (in_valid && in_ready) begin
        case (in_cmd)
          C_SAMPLE: begin
            int y;
            res_t r;
            for (int k = NUM_PE - 1; k > 0; k--) begin
              hx[k] = hx[k-1];
              hw[k] = hw[k-1];
            end
            hx[0] = int'($signed(in_data));
            hw[0] = mw;
            y = 0;
            for (int k = 0; k < NUM_PE; k++) y += hw[k][k] * hx[k];
            shape_out(y, r.d, r.s);
            q.push_back(r);
          end
          C_WEIGHT: begin
            mw[mptr] = int'($signed(in_data));
            mptr = (mptr + 1) % NUM_PE;
          end
          C_CLEAR: begin
            for (int k = 0; k < NUM_PE; k++) begin
              hx[k] = 0;
              for (int j = 0; j < NUM_PE; j++) hw[k][j] = 0;
            end
            mptr = 0;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic beat(input logic [1:0] c, input logic [7:0] d);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_cmd   = c;
    in_data  = d;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_timeout: cmd=%0d never accepted within 50 cycles", c);
      in_valid = 1'b0;
      in_cmd   = C_NOP;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_cmd   = C_NOP;
    end
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] data;
    bit         chk_y;
    int         exp_y;
    int         exp_wptr;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_big;
    int exp_neg;
    int exp_sat;
    tbl[0] = '{C_WEIGHT, 8'd1, 1'b0, 0, 1};
    tbl[1] = '{C_WEIGHT, 8'd2, 1'b0, 0, 2};
    tbl[2] = '{C_WEIGHT, 8'd3, 1'b0, 0, 3};
    tbl[3] = '{C_WEIGHT, 8'd4, 1'b0, 0, 0};
    tbl[4] = '{C_SAMPLE, 8'd1, 1'b1, 1, 0};
    tbl[5] = '{C_SAMPLE, 8'd0, 1'b1, 2, 0};
    tbl[6] = '{C_SAMPLE, 8'd0, 1'b1, 3, 0};
    tbl[7] = '{C_SAMPLE, 8'd0, 1'b1, 4, 0};
    tbl[8] = '{C_SAMPLE, 8'd0, 1'b1, 0, 0};
`ifdef SYSTOLIC_FIR_SAT_EN
    exp_big = 32767;  exp_neg = -32768; exp_sat = 1;
`else
    exp_big = -1020;  exp_neg = 512;    exp_sat = 0;
`endif

    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_cmd = C_NOP; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_wptr", int'(wptr), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", int'(in_ready), 1);

    // impulse response, back-to-back beats
    for (int i = 0; i < 9; i++) begin
      beat(tbl[i].cmd, tbl[i].data);
      check($sformatf("tbl%0d_wptr", i), int'(wptr), tbl[i].exp_wptr);
      if (tbl[i].chk_y) begin
        check($sformatf("tbl%0d_valid", i), int'(out_valid), 1);
        check($sformatf("tbl%0d_y", i), int'($signed(out_data)), tbl[i].exp_y);
      end
    end

    // backpressure
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;
    beat(C_SAMPLE, 8'd2);
    check("bp_y", int'($signed(out_data)), 2);
    in_valid = 1'b1; in_cmd = C_SAMPLE; in_data = 8'd5;
    @(negedge clk);
    check("bp_in_ready", int'(in_ready), 0);
    repeat (3) @(negedge clk);
    check("bp_hold_valid", int'(out_valid), 1);
    check("bp_hold_data", int'($signed(out_data)), 2);
    @(posedge clk); #1;
    in_valid = 1'b0; in_cmd = C_NOP;
    beat(C_WEIGHT, 8'd1);
    check("bp_weight_wptr", int'(wptr), 1);
    check("bp_weight_data_hold", int'($signed(out_data)), 2);
    beat(C_WEIGHT, 8'd2);
    beat(C_WEIGHT, 8'd3);
    beat(C_WEIGHT, 8'd4);
    out_ready = 1'b1;

    // clear
    beat(C_SAMPLE, 8'd5);
    beat(C_WEIGHT, 8'd1);
    check("clr_pre_wptr", int'(wptr), 1);
    beat(C_CLEAR, 8'd0);
    check("clr_wptr", int'(wptr), 0);
    beat(C_SAMPLE, 8'd0);
    check("clr_y0", int'($signed(out_data)), 0);
    beat(C_SAMPLE, 8'd1);
    check("clr_w_intact", int'($signed(out_data)), 1);

    // pointer wrap
    beat(C_CLEAR, 8'd0);
    beat(C_WEIGHT, 8'd9);
    beat(C_WEIGHT, 8'd1);
    beat(C_WEIGHT, 8'd1);
    beat(C_WEIGHT, 8'd1);
    beat(C_WEIGHT, 8'd7);
    check("wrap_wptr", int'(wptr), 1);
    beat(C_SAMPLE, 8'd1);
    check("wrap_y", int'($signed(out_data)), 7);

    // positive overflow
    beat(C_CLEAR, 8'd0);
    repeat (4) beat(C_WEIGHT, 8'd127);
    repeat (4) beat(C_SAMPLE, 8'd127);
    check("ovf_pos_y", int'($signed(out_data)), exp_big);
    check("ovf_pos_sat", int'(out_sat), exp_sat);

    // negative overflow
    beat(C_CLEAR, 8'd0);
    repeat (4) beat(C_WEIGHT, 8'h80);
    repeat (4) beat(C_SAMPLE, 8'd127);
    check("ovf_neg_y", int'($signed(out_data)), exp_neg);
    check("ovf_neg_sat", int'(out_sat), exp_sat);

    // ena low freezes everything
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;
    beat(C_SAMPLE, 8'd1);
    ena = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_cmd = C_WEIGHT; in_data = 8'd3;
    @(negedge clk);
    check("ena_in_ready", int'(in_ready), 0);
    repeat (2) @(negedge clk);
    check("ena_hold_valid", int'(out_valid), 1);
    check("ena_hold_wptr", int'(wptr), 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_cmd = C_NOP;
    ena = 1'b1;
    repeat (2) @(posedge clk); #1;

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    beat(C_WEIGHT, 8'd5);
    beat(C_SAMPLE, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out_data", int'(out_data), 0);
    check("arst_wptr", int'(wptr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_cmd = C_SAMPLE; in_data = 8'd3;
    #1;
    check("arst_in_ready", int'(in_ready), 1);
    beat(C_SAMPLE, 8'd3);
    check("arst_y", int'($signed(out_data)), 0);

    repeat (3) @(posedge clk); #1;
    check("sb_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
